// File: rtl/accel_sequencer.sv
// ADXL362 command sequencer: power-up wait, configuration writes, then periodic
// X/Y/Z register reads published as one coherent sample.
module accel_sequencer #(
  parameter int unsigned STARTUP_CYCLES = 500000,
  parameter int unsigned SAMPLE_PERIOD  = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ENABLE,
  input  logic       SPI_BUSY,
  input  logic       SPI_DONE,
  input  logic [7:0] SPI_RDATA,
  output logic       SPI_REQ,
  output logic [1:0] SPI_OP,
  output logic [7:0] SPI_ADDR,
  output logic [7:0] SPI_WDATA,
  output logic [7:0] X_DATA,
  output logic [7:0] Y_DATA,
  output logic [7:0] Z_DATA,
  output logic       SAMPLE_VALID,
  output logic       CONFIGURED,
  output logic       ERROR
);

  localparam int SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int PW = (SAMPLE_PERIOD  > 1) ? $clog2(SAMPLE_PERIOD)  : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b10;

  // Step index: two config writes followed by the three axis reads.
  localparam logic [2:0] STEP_CFG0 = 3'd0;
  localparam logic [2:0] STEP_CFG1 = 3'd1;
  localparam logic [2:0] STEP_RDX  = 3'd2;
  localparam logic [2:0] STEP_RDY  = 3'd3;
  localparam logic [2:0] STEP_RDZ  = 3'd4;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] wdata;
  } spi_txn_t;

  typedef enum logic [2:0] {
    ST_STARTUP, ST_ISSUE, ST_WAIT, ST_SAMPLE, ST_PUBLISH
  } state_e;

  state_e          state_q;
  logic [2:0]      step_q;
  logic [SW-1:0]   scnt_q;
  logic [PW-1:0]   pcnt_q;
  logic [TW-1:0]   tcnt_q;
  spi_txn_t        txn_q, txn_d;
  logic [7:0]      shx_q, shy_q;
  logic [7:0]      x_q, y_q, z_q;
  logic            valid_q, cfg_q, err_q;

  function automatic spi_txn_t txn_of(input logic [2:0] s);
    spi_txn_t t;
    case (s)
      STEP_CFG0: t = '{op: OP_WR, addr: 8'h2C, wdata: 8'h13};
      STEP_CFG1: t = '{op: OP_WR, addr: 8'h2D, wdata: 8'h02};
      STEP_RDX:  t = '{op: OP_RD, addr: 8'h08, wdata: 8'h00};
      STEP_RDY:  t = '{op: OP_RD, addr: 8'h09, wdata: 8'h00};
      STEP_RDZ:  t = '{op: OP_RD, addr: 8'h0A, wdata: 8'h00};
      default:   t = '0;
    endcase
    return t;
  endfunction

  // Descriptor for the step that follows the current one within a sequence.
  always_comb begin
    txn_d = txn_of(step_q + 3'd1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_STARTUP;
      step_q  <= STEP_CFG0;
      scnt_q  <= '0;
      pcnt_q  <= '0;
      tcnt_q  <= '0;
      txn_q   <= '0;
      shx_q   <= '0;
      shy_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      valid_q <= 1'b0;
      cfg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        ST_STARTUP: begin
          if (scnt_q == SW'(STARTUP_CYCLES - 1)) begin
            scnt_q  <= '0;
            step_q  <= STEP_CFG0;
            txn_q   <= txn_of(STEP_CFG0);
            state_q <= ST_ISSUE;
          end else begin
            scnt_q <= scnt_q + 1'b1;
          end
        end
        ST_ISSUE: begin
          if (!SPI_BUSY) begin
            tcnt_q  <= '0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (SPI_DONE) begin
            if (step_q == STEP_RDX) shx_q <= SPI_RDATA;
            if (step_q == STEP_RDY) shy_q <= SPI_RDATA;
            if (step_q == STEP_CFG1) begin
              cfg_q   <= 1'b1;
              pcnt_q  <= '0;
              state_q <= ST_SAMPLE;
            end else if (step_q == STEP_RDZ) begin
              // Z bypasses its shadow so all three axes land on the same edge.
              x_q     <= shx_q;
              y_q     <= shy_q;
              z_q     <= SPI_RDATA;
              valid_q <= 1'b1;
              state_q <= ST_PUBLISH;
            end else begin
              step_q  <= step_q + 3'd1;
              txn_q   <= txn_d;
              state_q <= ST_ISSUE;
            end
          end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            cfg_q   <= 1'b0;
            scnt_q  <= '0;
            pcnt_q  <= '0;
            step_q  <= STEP_CFG0;
            state_q <= ST_STARTUP;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (ENABLE) begin
            if (pcnt_q == PW'(SAMPLE_PERIOD - 1)) begin
              pcnt_q  <= '0;
              step_q  <= STEP_RDX;
              txn_q   <= txn_of(STEP_RDX);
              state_q <= ST_ISSUE;
            end else begin
              pcnt_q <= pcnt_q + 1'b1;
            end
          end
        end
        ST_PUBLISH: state_q <= ST_SAMPLE;
        default:    state_q <= ST_STARTUP;
      endcase
    end
  end

  // Request is gated by BUSY in the same cycle so it is never raised into a busy master.
  assign SPI_REQ      = (state_q == ST_ISSUE) && !SPI_BUSY;
  assign SPI_OP       = txn_q.op;
  assign SPI_ADDR     = txn_q.addr;
  assign SPI_WDATA    = txn_q.wdata;
  assign X_DATA       = x_q;
  assign Y_DATA       = y_q;
  assign Z_DATA       = z_q;
  assign SAMPLE_VALID = valid_q;
  assign CONFIGURED   = cfg_q;
  assign ERROR        = err_q;

endmodule

// File: tb/tb_accel_sequencer.sv
// Directed-flow bench for accel_sequencer with a latency-programmable SPI master
// model and a transaction-level reference for expected requests and samples.
module tb_accel_sequencer;

  localparam int SC  = 10;
  localparam int SP  = 50;
  localparam int TO  = 40;
  localparam int LAT = 5;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       ENABLE = 1'b0;
  logic       SPI_BUSY = 1'b0;
  logic       SPI_DONE = 1'b0;
  logic [7:0] SPI_RDATA = 8'h00;
  logic       SPI_REQ;
  logic [1:0] SPI_OP;
  logic [7:0] SPI_ADDR, SPI_WDATA, X_DATA, Y_DATA, Z_DATA;
  logic       SAMPLE_VALID, CONFIGURED, ERROR;

  always #5 CLK = ~CLK;

  accel_sequencer #(
    .STARTUP_CYCLES(SC), .SAMPLE_PERIOD(SP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .SPI_BUSY(SPI_BUSY),
    .SPI_DONE(SPI_DONE), .SPI_RDATA(SPI_RDATA), .SPI_REQ(SPI_REQ),
    .SPI_OP(SPI_OP), .SPI_ADDR(SPI_ADDR), .SPI_WDATA(SPI_WDATA),
    .X_DATA(X_DATA), .Y_DATA(Y_DATA), .Z_DATA(Z_DATA),
    .SAMPLE_VALID(SAMPLE_VALID), .CONFIGURED(CONFIGURED), .ERROR(ERROR)
  );

  int          ncyc = 0, pass_cnt = 0, total_cnt = 0;
  int          pend = 0, lat = LAT, valid_cnt = 0, done_cyc = 0;
  int          rel, pub_cyc, c;
  bit          suppress = 0, busy_force = 0, spur = 0, outst = 0;
  bit          stab_bad = 0, mix_bad = 0;
  logic [17:0] l_txn;
  logic [23:0] prev_xyz = '0, last_pub = '0;
  logic [7:0]  rd_val = '0, x4;

  // Reference: the sensor register map the sequencer must drive.
  function automatic logic [17:0] exp_cfg(input int i);
    return (i == 0) ? {2'b10, 8'h2C, 8'h13} : {2'b10, 8'h2D, 8'h02};
  endfunction

  function automatic logic [17:0] exp_rd(input int axis);
    return {2'b00, 8'h08 + 8'(axis), 8'h00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: drive SPI model inputs at negedge, then sample the DUT.
  task automatic cyc();
    @(negedge CLK);
    SPI_DONE  = 1'b0;
    SPI_RDATA = 8'($urandom);
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        SPI_DONE  = 1'b1;
        SPI_RDATA = rd_val;
      end
    end
    if (spur) begin
      SPI_DONE  = 1'b1;
      SPI_RDATA = 8'hEE;
    end
    SPI_BUSY = (pend > 0) || busy_force;
    #1;
    ncyc++;
    if (outst && ({SPI_OP, SPI_ADDR, SPI_WDATA} !== l_txn)) stab_bad = 1;
    if (SPI_DONE && !spur) begin
      done_cyc = ncyc;
      outst    = 0;
    end
    if (SPI_REQ) begin
      pend  = suppress ? 0 : lat;
      outst = 1;
      l_txn = {SPI_OP, SPI_ADDR, SPI_WDATA};
    end
    if (({X_DATA, Y_DATA, Z_DATA} !== prev_xyz) && !SAMPLE_VALID) mix_bad = 1;
    prev_xyz = {X_DATA, Y_DATA, Z_DATA};
    if (SAMPLE_VALID) valid_cnt++;
  endtask

  task automatic expect_req(input string tag, input logic [17:0] exp_txn, input int exp_cyc);
    int n = 0;
    do begin cyc(); n++; end while (!SPI_REQ && n < 400);
    chk({tag, "_seen"}, 32'(SPI_REQ), 32'd1);
    chk({tag, "_txn"}, 32'({SPI_OP, SPI_ADDR, SPI_WDATA}), 32'(exp_txn));
    chk({tag, "_cycle"}, 32'(ncyc), 32'(exp_cyc));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin cyc(); n++; end while (!SPI_DONE && n < 100);
    chk({tag, "_done"}, 32'(SPI_DONE), 32'd1);
  endtask

  task automatic sample_seq(input string tag, input int x_cyc, input int x_lat, input int hold);
    logic [7:0] v[3];
    bit bad_req, bad_addr;
    for (int i = 0; i < 3; i++) v[i] = 8'($urandom);
    if (hold > 0) begin
      while (ncyc < x_cyc - 1) cyc();
      busy_force = 1; bad_req = 0; bad_addr = 0;
      repeat (hold) begin
        cyc();
        if (SPI_REQ) bad_req = 1;
        if (SPI_ADDR !== 8'h08) bad_addr = 1;
      end
      busy_force = 0;
      chk({tag, "_busy_noreq"}, 32'(bad_req), 32'd0);
      chk({tag, "_busy_addr"}, 32'(bad_addr), 32'd0);
    end
    lat = x_lat;
    expect_req({tag, "_x"}, exp_rd(0), x_cyc + hold);
    lat = LAT;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) expect_req({tag, "_y"}, exp_rd(1), done_cyc + 1);
      if (i == 2) expect_req({tag, "_z"}, exp_rd(2), done_cyc + 1);
      rd_val = v[i];
      wait_done({tag, "_rd"});
    end
    cyc();
    chk({tag, "_valid"}, 32'(SAMPLE_VALID), 32'd1);
    chk({tag, "_xyz"}, 32'({X_DATA, Y_DATA, Z_DATA}), 32'({v[0], v[1], v[2]}));
    last_pub = {v[0], v[1], v[2]};
    pub_cyc  = ncyc;
  endtask

  initial begin
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    ENABLE = 1'b1;
    cyc(); cyc();
    chk("reset_ctrl", 32'({SPI_REQ, SPI_OP, SPI_ADDR, SPI_WDATA, SAMPLE_VALID, CONFIGURED, ERROR}), 32'd0);
    chk("reset_xyz", 32'({X_DATA, Y_DATA, Z_DATA}), 32'd0);
    RST_N = 1'b1;
    rel = ncyc;

    // Configuration writes
    expect_req("cfg0", exp_cfg(0), rel + SC);
    wait_done("cfg0");
    expect_req("cfg1", exp_cfg(1), done_cyc + 1);
    wait_done("cfg1");
    chk("cfg_not_yet", 32'(CONFIGURED), 32'd0);
    cyc();
    chk("configured", 32'(CONFIGURED), 32'd1);

    // First sample waits a full period
    sample_seq("s1", done_cyc + 1 + SP, LAT, 0);

    // ENABLE low at counter 20 for 100 cycles, stray DONE while idle, DONE on last timeout cycle
    while (ncyc < pub_cyc + 21) cyc();
    ENABLE = 1'b0;
    while (ncyc < pub_cyc + 60) cyc();
    spur = 1; cyc(); spur = 0;
    while (ncyc < pub_cyc + 121) cyc();
    ENABLE = 1'b1;
    sample_seq("s2", pub_cyc + 151, TO, 0);
    chk("edge_timeout_noerr", 32'(ERROR), 32'd0);
    chk("edge_timeout_cfg", 32'(CONFIGURED), 32'd1);

    // Master busy when the read is due
    sample_seq("s3", pub_cyc + 1 + SP, LAT, 20);

    // Timeout on the Y read
    x4 = 8'($urandom);
    expect_req("s4_x", exp_rd(0), pub_cyc + 1 + SP);
    rd_val = x4;
    wait_done("s4_x");
    suppress = 1;
    expect_req("s4_y", exp_rd(1), done_cyc + 1);
    suppress = 0;
    c = ncyc;
    while (ncyc < c + TO) cyc();
    chk("to_err_before", 32'(ERROR), 32'd0);
    cyc();
    chk("to_err", 32'(ERROR), 32'd1);
    chk("to_cfg_clr", 32'(CONFIGURED), 32'd0);
    chk("to_keep_xyz", 32'({X_DATA, Y_DATA, Z_DATA}), 32'(last_pub));
    outst = 0;
    expect_req("recfg0", exp_cfg(0), c + TO + 1 + SC);
    wait_done("recfg0");
    expect_req("recfg1", exp_cfg(1), done_cyc + 1);
    wait_done("recfg1");
    cyc();
    chk("recfg_done", 32'(CONFIGURED), 32'd1);
    chk("err_sticky", 32'(ERROR), 32'd1);

    // Asynchronous reset in the middle of a read request
    expect_req("s5_x", exp_rd(0), done_cyc + 1 + SP);
    #2 RST_N = 1'b0;
    #1;
    chk("areset_ctrl", 32'({SPI_REQ, SPI_OP, SPI_ADDR, SPI_WDATA, SAMPLE_VALID, CONFIGURED, ERROR}), 32'd0);
    chk("areset_xyz", 32'({X_DATA, Y_DATA, Z_DATA}), 32'd0);
    pend = 0; outst = 0; prev_xyz = '0;
    cyc(); cyc();
    RST_N = 1'b1;
    rel = ncyc;
    expect_req("restart_cfg0", exp_cfg(0), rel + SC);
    chk("restart_err", 32'(ERROR), 32'd0);

    chk("txn_stable", 32'(stab_bad), 32'd0);
    chk("no_axis_mix", 32'(mix_bad), 32'd0);
    chk("valid_pulses", 32'(valid_cnt), 32'd3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
